mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16: maximum consecutive cycles a lock may hold the grant (range 2..255).
REQ-002 SHALL have port clk_i, input, 1: the single clock.
REQ-003 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port m0_req_i, input, 1: core requester access request.
REQ-005 SHALL have ports m0_wren_i (1), m0_funct3_i (3), m0_addr_i (32) and m0_wdata_i (32), all inputs: the core access attributes.
REQ-006 SHALL have port m0_lock_i, input, 1: core requests an atomic hold (present only with ARB_LOCK_EN).
REQ-007 SHALL have ports m0_gnt_o (1), m0_rvalid_o (1) and m0_rdata_o (32), all outputs: grant, read-valid and read data to the core.
REQ-008 SHALL have ports m1_req_i, m1_wren_i, m1_funct3_i, m1_addr_i, m1_wdata_i, m1_lock_i, m1_gnt_o, m1_rvalid_o and m1_rdata_o: the same set for the debug/loader requester, with identical widths.
REQ-009 SHALL have ports lsu_wren_o (1), lsu_funct3_o (3), lsu_addr_o (32) and st_data_o (32), all outputs: the single shared load/store port.
REQ-010 SHALL have port ld_data_i, input, 32: LSU load data, valid in the cycle after the address is presented.

Function
REQ-011 SHALL perform at most one access per cycle; a grant is combinational in the same cycle as the request (address phase).
REQ-012 SHALL, when exactly one requester asserts req, grant that requester.
REQ-013 SHALL, when both requesters assert req in state ARB, grant the requester that did not receive the last grant (round-robin pointer last_q).
REQ-014 SHALL drive the lsu_* outputs from the granted requester; with no grant, lsu_wren_o=0 and lsu_funct3_o, lsu_addr_o and st_data_o are all 0.
REQ-015 SHALL register, for each granted read (wren=0), the owner index; in the next cycle it SHALL assert that owner's rvalid_o for exactly 1 cycle, with rdata_o=ld_data_i.
REQ-016 SHALL drive the non-owner's rdata_o to 0 and its rvalid_o low.
REQ-017 SHALL NOT produce rvalid for writes.
REQ-018 SHALL hold back-to-back grants to the same requester at a sustained rate of 1 per cycle when the other requester is idle.
REQ-019 SHALL implement FSM states ARB and LOCKED; without ARB_LOCK_EN, the FSM is permanently in ARB.
REQ-020 SHALL, in ARB, move to LOCKED when the granted requester asserts lock together with req; the lock owner is then recorded in lock_own_q and the counter is set to 1.
REQ-021 SHALL, in LOCKED, grant only lock_own_q, and only while its req is asserted; the other requester's requests stall (gnt=0).
REQ-022 SHALL leave LOCKED for ARB when the owner deasserts lock, or when the counter reaches LOCK_MAX (timeout).
REQ-023 SHALL, on timeout, set last_q=lock_own_q so that the other requester wins the next contention.
REQ-024 SHALL ignore lock asserted by a non-granted requester.
REQ-025 SHALL saturate the counter at LOCK_MAX and never wrap it.
REQ-026 SHALL keep all outputs for an access stable for the grant cycle only; a requester not granted SHALL hold its attributes until granted.

Reset
REQ-027 SHALL, while rst_ni is low, drive state=ARB, last_q=1 (m0 wins the first contention), lock counter=0, and both rvalid_o=0; gnt_o follows the REQ-012/013 rules from these reset values.
REQ-028 SHALL discard a pending read response when reset is asserted mid-transaction: no rvalid after rst_ni is released.

Configuration
REQ-029 SHALL compile the lock feature only when macro ARB_LOCK_EN is defined: m0_lock_i/m1_lock_i ports, the LOCKED state and the counter exist.
REQ-030 SHALL, without ARB_LOCK_EN, omit the lock ports and counter and behave as pure round-robin; LOCK_MAX is then unused.

Structure
REQ-031 SHALL place in shared package mem_arb_pkg: the state enum (ARB, LOCKED), the owner typedef (1 bit), the mem_req_t struct {wren, funct3, addr, wdata}, and the constant NUM_REQ=2.
REQ-032 SHALL instantiate one sub-module arb_rr2: a combinational two-way round-robin grant from req[1:0] and last_q.

Verification
REQ-033 SHALL verify: only m0 reads at addr 0x0001_0004 -> m0_gnt_o=1 in the same cycle; the next cycle m0_rvalid_o=1 and m0_rdata_o=ld_data_i (0xDEAD_BEEF); m1_rvalid_o=0.
REQ-034 SHALL verify: both requesters request continuously for 4 cycles after reset -> grants go m0, m1, m0, m1.
REQ-035 SHALL verify: m1 writes word 0x1234_5678 to 0x0002_0000 -> lsu_wren_o=1, st_data_o=0x1234_5678, lsu_funct3_o=3'b010, and no rvalid.
REQ-036 SHALL verify (ARB_LOCK_EN, LOCK_MAX=4): m0 holds req+lock while m1 requests -> m0 is granted for 4 cycles, then m1 is granted on the next cycle.
REQ-037 SHALL verify: reset is pulsed in the cycle after a granted m0 read -> m0_rvalid_o stays 0, and the first contention after reset goes to m0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter.
// The lock feature in the top level is built only with `define ARB_LOCK_EN.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef logic owner_t;

    typedef struct packed {
        logic        wren;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin grant: on contention the requester that
// did not win last time is granted.
import mem_arb_pkg::*;

module arb_rr2 (
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a core (m0) and a debug/loader (m1) onto one load/store port.
// Atomic lock hold with timeout exists only when ARB_LOCK_EN is defined.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic        m0_wren_i,
    input  logic [2:0]  m0_funct3_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
`ifdef ARB_LOCK_EN
    input  logic        m0_lock_i,
`endif
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic        m1_wren_i,
    input  logic [2:0]  m1_funct3_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
`ifdef ARB_LOCK_EN
    input  logic        m1_lock_i,
`endif
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        lsu_wren_o,
    output logic [2:0]  lsu_funct3_o,
    output logic [31:0] lsu_addr_o,
    output logic [31:0] st_data_o,
    input  logic [31:0] ld_data_i
);

    if (LOCK_MAX < 2 || LOCK_MAX > 255) begin : g_lock_max_range
        $error("LOCK_MAX must be within 2..255");
    end

    mem_req_t        attr [NUM_REQ];
    mem_req_t        sel;
    logic [1:0]      req_vec;
    logic [1:0]      rr_gnt;
    logic [1:0]      gnt;
    owner_t          last_q, last_d;
    logic            rd_pend_q;
    owner_t          rd_own_q;

    assign attr[0] = '{wren: m0_wren_i, funct3: m0_funct3_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign attr[1] = '{wren: m1_wren_i, funct3: m1_funct3_i, addr: m1_addr_i, wdata: m1_wdata_i};
    assign req_vec = {m1_req_i, m0_req_i};

    arb_rr2 u_rr (
        .req  (req_vec),
        .last (last_q),
        .gnt  (rr_gnt)
    );

`ifdef ARB_LOCK_EN
    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    arb_state_e  state_q, state_d;
    owner_t      lock_own_q, lock_own_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]  lock_vec;

    assign lock_vec = {m1_lock_i, m0_lock_i};

    always_comb begin
        state_d    = state_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        gnt        = rr_gnt;
        last_d     = last_q;
        unique case (state_q)
            ARB: begin
                if (|gnt) last_d = gnt[1];
                // Only the requester actually granted can take the lock.
                if (|(gnt & lock_vec)) begin
                    state_d    = LOCKED;
                    lock_own_d = gnt[1];
                    lock_cnt_d = 8'd1;
                end
            end
            LOCKED: begin
                gnt             = '0;
                gnt[lock_own_q] = req_vec[lock_own_q];
                if (|gnt) last_d = lock_own_q;
                if (lock_cnt_q != LOCK_MAX_C) lock_cnt_d = lock_cnt_q + 8'd1;
                if (lock_cnt_d == LOCK_MAX_C || !lock_vec[lock_own_q]) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                    // Timeout hands the next contention to the other requester.
                    if (lock_cnt_d == LOCK_MAX_C) last_d = lock_own_q;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB;
            lock_own_q <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    always_comb begin
        gnt    = rr_gnt;
        last_d = last_q;
        if (|gnt) last_d = gnt[1];
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_own_q  <= 1'b0;
        end else begin
            last_q    <= last_d;
            rd_pend_q <= |gnt && !sel.wren;
            rd_own_q  <= gnt[1];
        end
    end

    always_comb begin
        sel = '0;
        if (gnt[0])      sel = attr[0];
        else if (gnt[1]) sel = attr[1];
    end

    assign m0_gnt_o     = gnt[0];
    assign m1_gnt_o     = gnt[1];
    assign lsu_wren_o   = sel.wren;
    assign lsu_funct3_o = sel.funct3;
    assign lsu_addr_o   = sel.addr;
    assign st_data_o    = sel.wdata;

    assign m0_rvalid_o  = rd_pend_q && !rd_own_q;
    assign m1_rvalid_o  = rd_pend_q && rd_own_q;
    assign m0_rdata_o   = m0_rvalid_o ? ld_data_i : '0;
    assign m1_rdata_o   = m1_rvalid_o ? ld_data_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a behavioural model.
// Lock scenarios are exercised only when ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_wren, m1_req, m1_wren;
    logic [2:0]  m0_f3, m1_f3;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        lsu_wren;
    logic [2:0]  lsu_f3;
    logic [31:0] lsu_addr, st_data, ld_data;
`ifdef ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_last, m_pend, m_pend_own;
`ifdef ARB_LOCK_EN
    bit m_locked, m_own;
    int m_cycles;
`endif

    bit [1:0]    obs_gnt;
    bit          obs_rv0;
    logic [31:0] obs_rd0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .m0_req_i     (m0_req),
        .m0_wren_i    (m0_wren),
        .m0_funct3_i  (m0_f3),
        .m0_addr_i    (m0_addr),
        .m0_wdata_i   (m0_wdata),
`ifdef ARB_LOCK_EN
        .m0_lock_i    (m0_lock),
`endif
        .m0_gnt_o     (m0_gnt),
        .m0_rvalid_o  (m0_rvalid),
        .m0_rdata_o   (m0_rdata),
        .m1_req_i     (m1_req),
        .m1_wren_i    (m1_wren),
        .m1_funct3_i  (m1_f3),
        .m1_addr_i    (m1_addr),
        .m1_wdata_i   (m1_wdata),
`ifdef ARB_LOCK_EN
        .m1_lock_i    (m1_lock),
`endif
        .m1_gnt_o     (m1_gnt),
        .m1_rvalid_o  (m1_rvalid),
        .m1_rdata_o   (m1_rdata),
        .lsu_wren_o   (lsu_wren),
        .lsu_funct3_o (lsu_f3),
        .lsu_addr_o   (lsu_addr),
        .st_data_o    (st_data),
        .ld_data_i    (ld_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last     = 1'b1;
        m_pend     = 1'b0;
        m_pend_own = 1'b0;
`ifdef ARB_LOCK_EN
        m_locked = 1'b0;
        m_own    = 1'b0;
        m_cycles = 0;
`endif
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_wren = 0; m0_f3 = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_wren = 0; m1_f3 = '0; m1_addr = '0; m1_wdata = '0;
        ld_data = '0;
`ifdef ARB_LOCK_EN
        m0_lock = 0; m1_lock = 0;
`endif
    endtask

    // One clock cycle: check all outputs mid-cycle, then advance the model.
    task automatic step();
        bit g0, g1;
        logic        e_wr;
        logic [2:0]  e_f3;
        logic [31:0] e_addr, e_wd;
        bit          e_rv0, e_rv1;
        @(negedge clk); #1;
        if (!rst_n) model_reset();
`ifdef ARB_LOCK_EN
        if (m_locked) begin
            g0 = !m_own && m0_req;
            g1 = m_own && m1_req;
        end else
`endif
        if (m0_req && m1_req) begin
            g0 = (m_last == 1'b1);
            g1 = (m_last == 1'b0);
        end else begin
            g0 = m0_req;
            g1 = m1_req;
        end
        if (g0)      begin e_wr = m0_wren; e_f3 = m0_f3; e_addr = m0_addr; e_wd = m0_wdata; end
        else if (g1) begin e_wr = m1_wren; e_f3 = m1_f3; e_addr = m1_addr; e_wd = m1_wdata; end
        else         begin e_wr = 0; e_f3 = 0; e_addr = 0; e_wd = 0; end
        e_rv0 = m_pend && !m_pend_own;
        e_rv1 = m_pend && m_pend_own;
        check("m0_gnt",   {31'b0, m0_gnt},    {31'b0, g0});
        check("m1_gnt",   {31'b0, m1_gnt},    {31'b0, g1});
        check("lsu_wren", {31'b0, lsu_wren},  {31'b0, e_wr});
        check("lsu_f3",   {29'b0, lsu_f3},    {29'b0, e_f3});
        check("lsu_addr", lsu_addr,           e_addr);
        check("st_data",  st_data,            e_wd);
        check("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, e_rv0});
        check("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, e_rv1});
        check("m0_rdata", m0_rdata, e_rv0 ? ld_data : 32'h0);
        check("m1_rdata", m1_rdata, e_rv1 ? ld_data : 32'h0);
        obs_gnt = {m1_gnt, m0_gnt};
        obs_rv0 = m0_rvalid;
        obs_rd0 = m0_rdata;
        @(posedge clk); #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_pend     = (g0 && !m0_wren) || (g1 && !m1_wren);
            m_pend_own = g1;
            if (g0 || g1) m_last = g1;
`ifdef ARB_LOCK_EN
            if (m_locked) begin
                m_cycles++;
                if (m_cycles >= LOCK_MAX) begin
                    m_locked = 0;
                    m_last   = m_own;
                end else if (!(m_own ? m1_lock : m0_lock)) begin
                    m_locked = 0;
                end
            end else if (g0 && m0_lock) begin
                m_locked = 1; m_own = 0; m_cycles = 1;
            end else if (g1 && m1_lock) begin
                m_locked = 1; m_own = 1; m_cycles = 1;
            end
`endif
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        do_reset();
        check("rst_gnt", {30'b0, obs_gnt}, 32'h0);

        // Single m0 read, data returned next cycle
        m0_req = 1; m0_f3 = 3'b010; m0_addr = 32'h0001_0004;
        step();
        check("rd_gnt", {30'b0, obs_gnt}, 32'h1);
        idle_inputs();
        ld_data = 32'hDEAD_BEEF;
        step();
        check("rd_rvalid", {31'b0, obs_rv0}, 32'h1);
        check("rd_data", obs_rd0, 32'hDEAD_BEEF);
        idle_inputs();

        // Continuous contention after reset alternates m0, m1, m0, m1
        do_reset();
        m0_req = 1; m1_req = 1;
        step(); check("rr0", {30'b0, obs_gnt}, 32'h1);
        step(); check("rr1", {30'b0, obs_gnt}, 32'h2);
        step(); check("rr2", {30'b0, obs_gnt}, 32'h1);
        step(); check("rr3", {30'b0, obs_gnt}, 32'h2);
        idle_inputs();

        // m1 word write: no read response follows
        m1_req = 1; m1_wren = 1; m1_f3 = 3'b010; m1_addr = 32'h0002_0000; m1_wdata = 32'h1234_5678;
        step();
        check("wr_gnt", {30'b0, obs_gnt}, 32'h2);
        idle_inputs();
        step();

`ifdef ARB_LOCK_EN
        // m0 lock times out after LOCK_MAX grants, then m1 wins
        do_reset();
        m0_req = 1; m0_lock = 1; m1_req = 1;
        for (int i = 0; i < LOCK_MAX; i++) begin
            step();
            check("lock_hold", {30'b0, obs_gnt}, 32'h1);
        end
        step();
        check("lock_timeout", {30'b0, obs_gnt}, 32'h2);
        idle_inputs();
        step();
`endif

        // Reset during the response cycle drops the pending read
        m0_req = 1; m0_addr = 32'h0000_0040;
        step();
        idle_inputs();
        rst_n = 0;
        step();
        check("rst_drop_rv", {31'b0, obs_rv0}, 32'h0);
        rst_n = 1;
        step();
        check("rst_drop_rv2", {31'b0, obs_rv0}, 32'h0);
        m0_req = 1; m1_req = 1;
        step();
        check("rst_first_win", {30'b0, obs_gnt}, 32'h1);
        idle_inputs();

        // Randomized traffic, including occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 2) != 0);
            m0_wren  = $urandom_range(0, 1);
            m1_wren  = $urandom_range(0, 1);
            m0_f3    = 3'($urandom_range(0, 7));
            m1_f3    = 3'($urandom_range(0, 7));
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            ld_data  = $urandom;
`ifdef ARB_LOCK_EN
            m0_lock  = ($urandom_range(0, 2) == 0);
            m1_lock  = ($urandom_range(0, 2) == 0);
`endif
            rst_n    = ($urandom_range(0, 63) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
